// File: rtl/tick_counter_ctrl_pkg.sv
// Shared board constants and counter-control types for the tick counter.
package tick_counter_ctrl_pkg;

    localparam int unsigned BOARD_CLK_HZ = 100_000_000;
    localparam int unsigned TICK_1HZ     = 1;
    localparam int unsigned TICK_1KHZ    = 1_000;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_STEP = 2'd2
    } cnt_op_e;

    // Load outranks a coincident tick; the tick is then discarded.
    function automatic cnt_op_e cnt_op(input logic load, input logic tick);
        cnt_op_e op;
        op = CNT_HOLD;
        if (load) begin
            op = CNT_LOAD;
        end else if (tick) begin
            op = CNT_STEP;
        end
        return op;
    endfunction

endpackage

// File: rtl/tick_counter_ctrl_tick_gen.sv
// Single-clock divider producing a one-cycle tick enable every CLK_HZ/TICK_HZ cycles.
module tick_gen
    import tick_counter_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = BOARD_CLK_HZ,
    parameter int unsigned TICK_HZ = TICK_1HZ
) (
    input  logic f_crys,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = (TICK_HZ == 0) ? 0 : CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    generate
        if (TICK_HZ == 0 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
            $error("tick_gen: CLK_HZ must be a non-zero multiple of TICK_HZ");
        end
        if (DIV < 2) begin : g_bad_div
            $error("tick_gen: divide ratio must be at least 2");
        end
    endgenerate

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic             at_last_c;

    assign at_last_c = (div_cnt_q == DIV_LAST);
    assign tick      = en & at_last_c;

    // clr restarts the period regardless of en; en=0 freezes the phase.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            if (at_last_c) begin
                div_cnt_d = '0;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge f_crys or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/tick_counter_ctrl.sv
// Modulo-N up/down tick counter with pause, load, wrap/saturate, terminal count and square wave.
module tick_counter_ctrl
    import tick_counter_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = BOARD_CLK_HZ,
    parameter int unsigned TICK_HZ = TICK_1HZ,
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             f_crys,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] b,
    output logic             tick,
    output logic             tc,
    output logic             sq
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2) begin : g_bad_mod_lo
            $error("tick_counter_ctrl: MODULUS must be at least 2");
        end
        if (64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_mod_hi
            $error("tick_counter_ctrl: MODULUS must not exceed 2**WIDTH");
        end
    endgenerate

    logic             tick_c;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic             sq_q;
    logic             sq_d;
    logic             at_top_c;
    logic             at_bot_c;
    cnt_op_e          op_c;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .f_crys (f_crys),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (load),
        .tick   (tick_c)
    );

    assign at_top_c = (b_q == CNT_MAX);
    assign at_bot_c = (b_q == '0);
    assign op_c     = cnt_op(load, tick_c);

    assign tick = tick_c;
    assign tc   = tick_c & ~load & (up ? at_top_c : at_bot_c);
    assign b    = b_q;
    assign sq   = sq_q;

    // Counter and square-wave next state; out-of-range loads clamp to the top value.
    always_comb begin
        b_d  = b_q;
        sq_d = sq_q;
        unique case (op_c)
            CNT_LOAD: begin
                b_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
            end
            CNT_STEP: begin
                sq_d = ~sq_q;
                if (up) begin
                    if (!at_top_c) begin
                        b_d = b_q + WIDTH'(1);
                    end else if (!sat) begin
                        b_d = '0;
                    end
                end else begin
                    if (!at_bot_c) begin
                        b_d = b_q - WIDTH'(1);
                    end else if (!sat) begin
                        b_d = CNT_MAX;
                    end
                end
            end
            default: begin
                b_d  = b_q;
                sq_d = sq_q;
            end
        endcase
    end

    always_ff @(posedge f_crys or negedge rst_n) begin
        if (!rst_n) begin
            b_q  <= '0;
            sq_q <= 1'b0;
        end else begin
            b_q  <= b_d;
            sq_q <= sq_d;
        end
    end

endmodule

// File: tb/tb_tick_counter_ctrl.sv
// Scoreboard bench for tick_counter_ctrl: reference model pushes per-cycle expectations, monitor compares.
module tb_tick_counter_ctrl;

    localparam int unsigned CLK_HZ  = 8;
    localparam int unsigned TICK_HZ = 1;
    localparam int unsigned WIDTH   = 4;
    localparam int unsigned MODULUS = 10;
    localparam int          DIV     = CLK_HZ / TICK_HZ;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] b;
    logic             tick;
    logic             tc;
    logic             sq;

    tick_counter_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ),
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) dut (
        .f_crys   (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .b        (b),
        .tick     (tick),
        .tc       (tc),
        .sq       (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int b;
        bit sq;
        bit tick;
        bit tc;
        int idx;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   n_push = 0;

    // Reference model state: cycles elapsed in the current period, count value, square wave.
    int m_phase = 0;
    int m_cnt   = 0;
    bit m_sq    = 0;

    task automatic check_bit(input string name, input logic act, input bit req, input int idx);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, idx, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req, input int idx);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, idx, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare them at mid-period.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (^b === 1'bx || int'(b) != e.b) begin
                fails++;
                $display("FAIL b cycle %0d: got %0d expected %0d", e.idx, b, e.b);
            end
            check_bit("sq", sq, e.sq, e.idx);
            check_bit("tick", tick, e.tick, e.idx);
            check_bit("tc", tc, e.tc, e.idx);
        end
    end

    // Drive one cycle of inputs just after the edge and record what the spec predicts.
    task automatic step(input bit r, input bit e, input bit u, input bit s,
                        input bit l, input int lv);
        exp_t x;
        bit   t;
        @(posedge clk);
        #1;
        rst_n    = r;
        en       = e;
        up       = u;
        sat      = s;
        load     = l;
        load_val = WIDTH'(lv);
        x.idx    = n_push++;
        if (!r) begin
            m_phase = 0;
            m_cnt   = 0;
            m_sq    = 0;
            x.b = 0; x.sq = 0; x.tick = 0; x.tc = 0;
            q.push_back(x);
        end else begin
            t      = e && (m_phase == DIV - 1);
            x.b    = m_cnt;
            x.sq   = m_sq;
            x.tick = t;
            x.tc   = t && !l && (u ? (m_cnt == MODULUS - 1) : (m_cnt == 0));
            q.push_back(x);
            if (l) begin
                m_cnt   = (lv > MODULUS - 1) ? MODULUS - 1 : lv;
                m_phase = 0;
            end else if (e) begin
                m_phase = (m_phase + 1) % DIV;
                if (t) begin
                    m_sq = !m_sq;
                    if (u) begin
                        if (!(s && m_cnt == MODULUS - 1)) m_cnt = (m_cnt + 1) % MODULUS;
                    end else begin
                        if (!(s && m_cnt == 0)) m_cnt = (m_cnt + MODULUS - 1) % MODULUS;
                    end
                end
            end
        end
    endtask

    task automatic run(input int n, input bit u, input bit s);
        for (int i = 0; i < n; i++) step(1, 1, u, s, 0, 0);
    endtask

    task automatic run_to_phase(input int ph, input bit u, input bit s);
        for (int i = 0; i < 2 * DIV && m_phase != ph; i++) step(1, 1, u, s, 0, 0);
        check_int("phase_align", m_phase, ph, n_push);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        up       = 1'b1;
        sat      = 1'b0;
        load     = 1'b0;
        load_val = '0;

        // Reset held, then release with en=1 up=1: first tick on the 8th cycle.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0);
        run(2 * DIV, 1, 0);

        // Up wrap across the full modulus.
        run(10 * DIV, 1, 0);

        // Down wrap from zero.
        step(1, 1, 0, 0, 1, 0);
        run(3 * DIV, 0, 0);

        // Saturate at top, then count down out of it.
        step(1, 1, 1, 1, 1, 9);
        run(3 * DIV, 1, 1);
        run(DIV, 0, 1);
        // Saturate at bottom.
        step(1, 1, 0, 1, 1, 0);
        run(2 * DIV, 0, 1);

        // Load mid-period, clamped load, and load coincident with a tick.
        run_to_phase(2, 1, 0);
        step(1, 1, 1, 0, 1, 5);
        run(DIV + 2, 1, 0);
        step(1, 1, 1, 0, 1, 12);
        run(3, 1, 0);
        run_to_phase(DIV - 1, 1, 0);
        step(1, 1, 1, 0, 1, 3);
        run(DIV + 1, 1, 0);
        run_to_phase(DIV - 1, 1, 0);
        step(1, 1, 1, 0, 1, 9);
        run(2, 1, 0);

        // Pause for 20 cycles mid-period, then resume.
        run_to_phase(3, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 6);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
        run(2 * DIV, 1, 0);

        // Asynchronous reset mid-period, away from any edge.
        step(1, 1, 1, 0, 1, 7);
        run(DIV + 3, 1, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("async_rst_b", int'(b), 0, n_push);
        check_bit("async_rst_sq", sq, 1'b0, n_push);
        check_bit("async_rst_tick", tick, 1'b0, n_push);
        for (int i = 0; i < 2; i++) step(0, 1, 1, 0, 0, 0);
        run(2 * DIV, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1,
                 $urandom_range(0, 9) != 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 24) == 0,
                 int'($urandom_range(0, 15)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
